// File: rtl/mb_scheduler_if.sv
// mb_scheduler_if
// Bundles the scheduler's extractor-side and consumer-side signals.
//   ext_enable : extractor fetch strobe (scheduler -> extractor)
//   mbnumber   : {row origin, col origin} of the current macroblock
//   mb_valid   : current macroblock offered to the consumer
//   mb_ready   : consumer accepts when mb_valid && mb_ready
//   mb_index   : raster index of the current macroblock
//   left_avail : left neighbour exists (col origin != 0)
//   top_avail  : top neighbour exists (row origin != 0)
// Modports: master = scheduler side, slave = extractor/consumer side.
interface mb_scheduler_if;
    logic        ext_enable;
    logic [31:0] mbnumber;
    logic        mb_valid;
    logic        mb_ready;
    logic [15:0] mb_index;
    logic        left_avail;
    logic        top_avail;

    modport master (
        output ext_enable, mbnumber, mb_valid, mb_index, left_avail, top_avail,
        input  mb_ready
    );

    modport slave (
        input  ext_enable, mbnumber, mb_valid, mb_index, left_avail, top_avail,
        output mb_ready
    );
endinterface

// File: rtl/mb_scheduler.sv
// mb_scheduler
// Walks every MB_SIZE x MB_SIZE macroblock of a WIDTH x LENGTH frame in
// raster order. Per macroblock: one FETCH cycle strobing the extractor,
// EXTRACT_LATENCY WAIT cycles, then an OFFER held until the consumer
// accepts. frame_done pulses for one cycle after the last acceptance.
// Ports:
//   clk        : sole clock, rising edge
//   reset      : asynchronous, active-low; returns everything to IDLE
//   start      : level-sampled frame start, honoured only in IDLE
//   abort      : synchronous return to IDLE from any state, no frame_done
//   mbif       : extractor/consumer bundle (master side)
//   busy       : high in every state except IDLE
//   frame_done : one-cycle pulse after the last macroblock handshake
module mb_scheduler #(
    parameter int WIDTH           = 1280,
    parameter int LENGTH          = 720,
    parameter int MB_SIZE         = 16,
    parameter int EXTRACT_LATENCY = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    mb_scheduler_if.master mbif,
    output logic           busy,
    output logic           frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_OFFER,
        S_DONE
    } state_t;

    localparam logic [15:0] COL_LAST  = 16'(WIDTH - MB_SIZE);
    localparam logic [15:0] ROW_LAST  = 16'(LENGTH - MB_SIZE);
    localparam logic [15:0] STEP      = 16'(MB_SIZE);
    localparam bit          HAS_WAIT  = (EXTRACT_LATENCY > 0);
    // WAIT counts down from latency-1 to 0, so it lasts exactly
    // EXTRACT_LATENCY cycles; unused when latency is 0.
    localparam logic [3:0]  WAIT_LOAD = HAS_WAIT ? 4'(EXTRACT_LATENCY - 1) : 4'd0;

    state_t      state, state_nxt;
    logic [15:0] row, col, idx;
    logic [3:0]  wcnt;
    logic        clear_pos;
    logic        advance;
    logic        last_mb;

    assign last_mb = (row == ROW_LAST) && (col == COL_LAST);

    // State register and position/counter bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            row   <= '0;
            col   <= '0;
            idx   <= '0;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;

            if (clear_pos) begin
                row <= '0;
                col <= '0;
                idx <= '0;
            end else if (advance) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + STEP;
                end else begin
                    col <= col + STEP;
                end
                idx <= idx + 16'd1;
            end

            if (state == S_FETCH) begin
                wcnt <= WAIT_LOAD;
            end else if ((state == S_WAIT) && (wcnt != 4'd0)) begin
                wcnt <= wcnt - 4'd1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        clear_pos = 1'b0;
        advance   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    clear_pos = 1'b1;
                end
            end
            S_FETCH: begin
                state_nxt = HAS_WAIT ? S_WAIT : S_OFFER;
            end
            S_WAIT: begin
                if (wcnt == 4'd0) begin
                    state_nxt = S_OFFER;
                end
            end
            S_OFFER: begin
                if (mbif.mb_ready) begin
                    if (last_mb) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_FETCH;
                        advance   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // abort wins over start and over a same-cycle handshake
        if (abort) begin
            state_nxt = S_IDLE;
            clear_pos = 1'b0;
            advance   = 1'b0;
        end
    end

    // Outputs decoded from registered state only; position-derived outputs
    // are forced to 0 in IDLE so the block is fully quiet there.
    assign busy            = (state != S_IDLE);
    assign frame_done      = (state == S_DONE);
    assign mbif.ext_enable = (state == S_FETCH);
    assign mbif.mb_valid   = (state == S_OFFER);
    assign mbif.mbnumber   = busy ? {row, col} : 32'd0;
    assign mbif.mb_index   = busy ? idx : 16'd0;
    assign mbif.left_avail = busy && (col != 16'd0);
    assign mbif.top_avail  = busy && (row != 16'd0);

endmodule
